// File: rtl/sum_accumulator.sv
// Frame accumulator for 5-bit ripple-carry adder results ({Cout,Sum}).
// Sums N_SAMPLES accepted samples with saturation, then holds the total until it is consumed.
module sum_accumulator #(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Sum,
    input  logic             Cout,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             overflow,
    output logic [7:0]       sample_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [7:0]       CNT_LAST = 8'(N_SAMPLES - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] sample;
    logic [ACC_W:0]   sum_ext;
    logic             accept;

    assign sample  = {{(ACC_W-5){1'b0}}, Cout, Sum};
    assign sum_ext = {1'b0, acc_q} + {1'b0, sample};
    assign accept  = in_valid && in_ready;

    // Handshake outputs decode only the state register, so no input-to-output paths exist.
    assign in_ready   = (state_q != S_DONE);
    assign acc_valid  = (state_q == S_DONE);
    assign busy       = (state_q == S_ACCUM);
    assign acc_out    = acc_q;
    assign sample_cnt = cnt_q;
    assign overflow   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = sample;
                    cnt_d   = 8'd1;
                    ovf_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (sum_ext[ACC_W]) begin
                        acc_d = ACC_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (acc_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over any accept on the same edge.
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized self-checking bench: default instance (8 samples) and a 16-sample instance for saturation.
module tb_sum_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clear, in_valid, Cout, acc_ready;
    logic [3:0] Sum;
    logic       in_ready, acc_valid, overflow, busy;
    logic [7:0] acc_out, sample_cnt;

    logic       b_clear, b_in_valid, b_Cout, b_acc_ready;
    logic [3:0] b_Sum;
    logic       b_in_ready, b_acc_valid, b_overflow, b_busy;
    logic [7:0] b_acc_out, b_sample_cnt;

    int errors = 0;
    int checks = 0;

    sum_accumulator #(.N_SAMPLES(8), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .Sum(Sum), .Cout(Cout), .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .overflow(overflow), .sample_cnt(sample_cnt), .busy(busy)
    );

    sum_accumulator #(.N_SAMPLES(16), .ACC_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .Sum(b_Sum), .Cout(b_Cout), .acc_out(b_acc_out), .acc_valid(b_acc_valid),
        .acc_ready(b_acc_ready), .overflow(b_overflow), .sample_cnt(b_sample_cnt), .busy(b_busy)
    );

    wire [19:0] a_obs = {acc_valid, overflow, busy, in_ready, sample_cnt, acc_out};
    wire [19:0] b_obs = {b_acc_valid, b_overflow, b_busy, b_in_ready, b_sample_cnt, b_acc_out};

    // Expected observation vector: {valid, overflow, busy, ready, count, total}
    function automatic logic [19:0] pack(input logic v, input logic o, input logic b,
                                         input logic r, input int cnt, input int acc);
        return {v, o, b, r, 8'(cnt), 8'(acc)};
    endfunction

    // Frame total is the plain sum clamped at the 8-bit ceiling.
    function automatic int sat(input int t);
        return (t > 255) ? 255 : t;
    endfunction

    // Drives n random samples back-to-back starting now (caller sits at a negedge),
    // then deasserts in_valid at the negedge following the last accept.
    task automatic send_a(input int n, output int total);
        logic [4:0] v;
        total = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            v = 5'($urandom_range(0, 31));
            total += int'(v);
            in_valid = 1'b1;
            {Cout, Sum} = v;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] e;
        rst_n = 1'b1;
        clear = 0; in_valid = 0; Cout = 0; Sum = 0; acc_ready = 0;
        b_clear = 0; b_in_valid = 0; b_Cout = 0; b_Sum = 0; b_acc_ready = 0;
        #1 rst_n = 1'b0;
        #2;
        e = pack(0, 0, 0, 1, 0, 0);
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL reset_a got %h exp %h", a_obs, e); end
        checks++;
        if (b_obs !== e) begin errors++; $display("FAIL reset_b got %h exp %h", b_obs, e); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [4:0]  vals [8];
        logic [19:0] e;
        int          total;
        vals = '{5'b00000, 5'b01000, 5'b10000, 5'b01111, 5'b10100, 5'b11110, 5'b10000, 5'b11111};
        total = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 7) begin
                e = pack(0, 0, 1, 1, 7, total);
                checks++;
                if (a_obs !== e) begin errors++; $display("FAIL basic_before_last got %h exp %h", a_obs, e); end
            end
            in_valid = 1'b1;
            {Cout, Sum} = vals[i];
            total += int'(vals[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = pack(1, 0, 0, 0, 8, 136);
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL basic_done got %h exp %h", a_obs, e); end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        e = pack(0, 0, 0, 1, 8, 136);
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL basic_consumed got %h exp %h", a_obs, e); end
    endtask

    task automatic test_gaps_hold();
        logic [19:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            {Cout, Sum} = 5'd31;
            @(negedge clk);
            in_valid = 1'b0;
            e = (i < 7) ? pack(0, 0, 1, 1, i + 1, 31 * (i + 1)) : pack(1, 0, 0, 0, 8, 248);
            checks++;
            if (a_obs !== e) begin errors++; $display("FAIL gaps_accept%0d got %h exp %h", i, a_obs, e); end
            if (i < 7) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    checks++;
                    if (a_obs !== e) begin errors++; $display("FAIL gaps_stall%0d got %h exp %h", i, a_obs, e); end
                end
            end
        end
        // upstream keeps offering data while the result is not consumed
        in_valid = 1'b1;
        {Cout, Sum} = 5'd7;
        e = pack(1, 0, 0, 0, 8, 248);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (a_obs !== e) begin errors++; $display("FAIL hold_done got %h exp %h", a_obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] e;
        @(negedge clk);
        acc_ready = 1'b1;
        in_valid  = 1'b1;
        {Cout, Sum} = 5'd9;
        @(negedge clk);
        acc_ready = 1'b0;
        e = pack(0, 0, 0, 1, 8, 248);
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL done_exit_no_accept got %h exp %h", a_obs, e); end
        @(negedge clk);
        in_valid = 1'b0;
        e = pack(0, 0, 1, 1, 1, 9);
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL next_first_accept got %h exp %h", a_obs, e); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        e = pack(0, 0, 0, 1, 0, 0);
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL clear_from_accum got %h exp %h", a_obs, e); end
    endtask

    task automatic test_clear();
        logic [19:0] e;
        logic [4:0]  v;
        int          total;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                e = pack(0, 0, 1, 1, 3, total);
                checks++;
                if (a_obs !== e) begin errors++; $display("FAIL clear_pre got %h exp %h", a_obs, e); end
                clear = 1'b1;
            end
            v = 5'($urandom_range(0, 31));
            total += int'(v);
            in_valid = 1'b1;
            {Cout, Sum} = v;
        end
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        e = pack(0, 0, 0, 1, 0, 0);
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL clear_with_accept got %h exp %h", a_obs, e); end
        send_a(8, total);
        e = pack(1, 0, 0, 0, 8, sat(total));
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL clear_next_frame got %h exp %h", a_obs, e); end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [19:0] e;
        int          total;
        send_a(5, total);
        e = pack(0, 0, 1, 1, 5, total);
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL arst_partial got %h exp %h", a_obs, e); end
        #2 rst_n = 1'b0;
        #1;
        e = pack(0, 0, 0, 1, 0, 0);
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL arst_immediate got %h exp %h", a_obs, e); end
        @(negedge clk);
        rst_n = 1'b1;
        send_a(8, total);
        e = pack(1, 0, 0, 0, 8, sat(total));
        checks++;
        if (a_obs !== e) begin errors++; $display("FAIL arst_fresh_frame got %h exp %h", a_obs, e); end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    task automatic test_saturation16();
        logic [19:0] e;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (f == 0 && i == 8) begin
                    e = pack(0, 0, 1, 1, 8, 248);
                    checks++;
                    if (b_obs !== e) begin errors++; $display("FAIL sat_below got %h exp %h", b_obs, e); end
                end
                if (f == 0 && i == 9) begin
                    e = pack(0, 1, 1, 1, 9, 255);
                    checks++;
                    if (b_obs !== e) begin errors++; $display("FAIL sat_clamp got %h exp %h", b_obs, e); end
                end
                if (f == 1 && i == 1) begin
                    e = pack(0, 0, 1, 1, 1, 0);
                    checks++;
                    if (b_obs !== e) begin errors++; $display("FAIL sat_ovf_cleared got %h exp %h", b_obs, e); end
                end
                b_in_valid = 1'b1;
                {b_Cout, b_Sum} = (f == 0) ? 5'd31 : 5'd0;
            end
            @(negedge clk);
            b_in_valid = 1'b0;
            e = (f == 0) ? pack(1, 1, 0, 0, 16, 255) : pack(1, 0, 0, 0, 16, 0);
            checks++;
            if (b_obs !== e) begin errors++; $display("FAIL sat_frame%0d got %h exp %h", f, b_obs, e); end
            b_acc_ready = 1'b1;
            @(negedge clk);
            b_acc_ready = 1'b0;
            e = (f == 0) ? pack(0, 1, 0, 1, 16, 255) : pack(0, 0, 0, 1, 16, 0);
            checks++;
            if (b_obs !== e) begin errors++; $display("FAIL sat_idle_hold%0d got %h exp %h", f, b_obs, e); end
        end
    endtask

    task automatic test_random();
        logic [19:0] e;
        logic [4:0]  v;
        int          total;
        for (int f = 0; f < 6; f++) begin
            total = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                v = 5'($urandom_range(0, 31));
                total += int'(v);
                b_in_valid = 1'b1;
                {b_Cout, b_Sum} = v;
                @(negedge clk);
                b_in_valid = 1'b0;
                if (i < 15) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            e = pack(1, total > 255, 0, 0, 16, sat(total));
            checks++;
            if (b_obs !== e) begin errors++; $display("FAIL rand_frame%0d got %h exp %h", f, b_obs, e); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b_acc_ready = 1'b1;
            @(negedge clk);
            b_acc_ready = 1'b0;
            e = pack(0, total > 255, 0, 1, 16, sat(total));
            checks++;
            if (b_obs !== e) begin errors++; $display("FAIL rand_consumed%0d got %h exp %h", f, b_obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_hold();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_saturation16();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter N_SAMPLES, default 8: number of adder results accumulated per frame, legal range 2..255.
REQ-002 Parameter ACC_W, default 8: accumulator width in bits, legal range 6..16.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 clear  input  1  synchronous abort of the current frame; active-high.
REQ-006 in_valid  input  1  upstream adder result present on Sum/Cout.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 Sum  input  4  ripple-carry adder sum bits.
REQ-009 Cout  input  1  ripple-carry adder carry-out.
REQ-010 acc_out  output  ACC_W  accumulated frame total.
REQ-011 acc_valid  output  1  acc_out holds a completed frame.
REQ-012 acc_ready  input  1  downstream consumes acc_out.
REQ-013 overflow  output  1  sticky per frame; set when the total saturated.
REQ-014 sample_cnt  output  8  samples accepted in the current frame.
REQ-015 busy  output  1  high in the ACCUM state.

Function
REQ-016 The sample value is the 5-bit unsigned {Cout,Sum}, range 0..31, zero-extended to ACC_W.
REQ-017 A sample is accepted on a rising edge where in_valid=1 and in_ready=1; there are no other accept conditions.
REQ-018 FSM states: IDLE, ACCUM and DONE; the encoding is implementation-defined.
REQ-019 IDLE: in_ready=1 and acc_valid=0; an accept loads acc_out with the sample, sets sample_cnt to 1, clears overflow and moves to ACCUM.
REQ-020 ACCUM: in_ready=1; an accept adds the sample to acc_out and increments sample_cnt.
REQ-021 ACCUM: on the accept that makes sample_cnt equal N_SAMPLES, the next state is DONE.
REQ-022 DONE: in_ready=0 and acc_valid=1; acc_out, overflow and sample_cnt are held stable.
REQ-023 DONE: on an edge with acc_ready=1, the next state is IDLE and acc_valid falls; sample_cnt and acc_out are held until the next frame's first accept.
REQ-024 Latency: acc_valid rises in the cycle immediately after the edge that accepts the N_SAMPLES-th sample.
REQ-025 Saturation: if acc_out + sample exceeds 2^ACC_W-1, acc_out becomes 2^ACC_W-1 and overflow is set.
REQ-026 Saturation: overflow stays set until the next frame's first accept.
REQ-027 Saturation: acc_out never wraps around.
REQ-028 in_valid=1 while in DONE is ignored; no sample is lost-counted, and the upstream producer holds its data.
REQ-029 acc_ready=1 outside DONE has no effect.
REQ-030 clear=1 on an edge forces IDLE and sets acc_out=0, sample_cnt=0 and overflow=0, regardless of state.
REQ-031 clear has priority over a simultaneous accept; that sample is discarded.
REQ-032 In ACCUM, in_valid=0 cycles (gaps) stall the frame with no state change.
REQ-033 No combinational path from in_valid to in_ready, or from acc_ready to acc_valid; in_ready is a function of state only.

Reset
REQ-034 While rst_n=0: state=IDLE, acc_out=0, acc_valid=0, overflow=0, sample_cnt=0, busy=0 and in_ready=1; these take effect immediately, independent of clk.
REQ-035 rst_n asserted mid-frame or in DONE discards the partial or unconsumed total; no output glitches to a stale value after release.
REQ-036 The first accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-037 Defaults: 8 back-to-back samples {Cout,Sum}=5'b00000, 5'b01000, 5'b10000, 5'b01111, 5'b10100, 5'b11110, 5'b10000, 5'b11111 (values 0, 8, 16, 15, 20, 30, 16, 31) -> acc_out=136, overflow=0, acc_valid high the cycle after the 8th accept.
REQ-038 Defaults: 8 samples of 31 with in_valid gaps between them -> acc_out=248, overflow=0, sample_cnt=8; in_ready=0 while acc_ready is held low for 5 cycles, and outputs stay stable during that hold.
REQ-039 N_SAMPLES=16: 16 samples of 31 -> acc_out=255, overflow=1; the next frame of 16 zeros -> acc_out=0, overflow=0.
REQ-040 Defaults: clear pulsed on the same edge as the 4th accept -> state IDLE, acc_out=0, sample_cnt=0; the following 8-sample frame totals correctly.
REQ-041 Defaults: rst_n driven low asynchronously between edges after 5 accepts -> outputs reach reset values before the next edge; after release, a fresh 8-sample frame completes.
REQ-042 Defaults: acc_ready=1 on the same edge that in_valid=1 in DONE -> DONE exits, that sample is not accepted, and the next in_valid is accepted as the first sample of the new frame.
